// File: rtl/hmmm_boot_loader.sv
// hmmm_boot_loader
//   Boot sequencer and memory-bus arbiter. While the core is held in reset a
//   host streams a load command ('L', start address, word count, then HI/LO
//   byte pairs) over a valid/ready byte link; each assembled word is written
//   to the external memory in a one-cycle WRITE state. 'G' hands the bus to
//   the core and releases its reset; 'H' takes the bus back.
// Ports:
//   ph1, reset                 clock, synchronous active-high reset
//   host_valid/data/ready      host byte link (ready decoded from state only)
//   cpu_adr/we/wdata           core bus, passed to memory only in RUN
//   mem_adr/wdata/we/be        external memory bus
//   cpu_reset                  core reset, high in every state except RUN
//   err                        sticky: unknown command byte seen in IDLE
//   words_loaded               words written since the last 'L'
module hmmm_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 15
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              host_valid,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic              cpu_reset,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADR,
    S_CNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_RUN
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_d;
  logic [ADDR_W-1:0] load_adr;
  logic [ADDR_W:0]   remaining;
  logic [6:0]        hi_q;
  logic [7:0]        lo_q;

  logic accept;
  logic set_err, clr_loaded, ld_adr, ld_cnt, ld_hi, ld_lo, adv;

  assign accept = host_valid & host_ready;

  always_ff @(posedge ph1) begin
    if (reset) begin
      state        <= S_IDLE;
      err          <= 1'b0;
      words_loaded <= '0;
      load_adr     <= '0;
      remaining    <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      cpu_reset    <= 1'b1;
    end else begin
      state     <= state_d;
      // Registered so cpu_reset changes on the same edge as the state it decodes
      cpu_reset <= (state_d != S_RUN);
      if (set_err)    err          <= 1'b1;
      if (clr_loaded) words_loaded <= '0;
      if (ld_adr)     load_adr     <= ADDR_W'(host_data);
      // A count byte of zero selects the full 2^ADDR_W words
      if (ld_cnt)     remaining    <= (host_data == 8'h00) ? CNT_FULL
                                                           : (ADDR_W+1)'(host_data);
      if (ld_hi)      hi_q         <= host_data[6:0];
      if (ld_lo)      lo_q         <= host_data;
      if (adv) begin
        load_adr     <= load_adr + 1'b1;
        words_loaded <= words_loaded + 1'b1;
        remaining    <= remaining - 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state;
    set_err    = 1'b0;
    clr_loaded = 1'b0;
    ld_adr     = 1'b0;
    ld_cnt     = 1'b0;
    ld_hi      = 1'b0;
    ld_lo      = 1'b0;
    adv        = 1'b0;

    host_ready = (state != S_WRITE);
    mem_adr    = load_adr;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_be     = 2'b00;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (host_data == 8'h4C) begin
            state_d    = S_ADR;
            clr_loaded = 1'b1;
          end else if (host_data == 8'h47) begin
            state_d = S_RUN;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      S_ADR: begin
        if (accept) begin
          ld_adr  = 1'b1;
          state_d = S_CNT;
        end
      end
      S_CNT: begin
        if (accept) begin
          ld_cnt  = 1'b1;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          ld_hi   = 1'b1;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          ld_lo   = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_be    = 2'b11;
        mem_wdata = WORD_W'({hi_q, lo_q});
        adv       = 1'b1;
        state_d   = (remaining == CNT_ONE) ? S_IDLE : S_HI;
      end
      S_RUN: begin
        mem_adr   = cpu_adr;
        mem_we    = cpu_we;
        mem_wdata = WORD_W'(cpu_wdata);
        mem_be    = {1'b0, cpu_we};
        if (accept && host_data == 8'h48) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hmmm_boot_loader.sv
module tb_hmmm_boot_loader;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_ready;
  logic [7:0]  cpu_adr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  mem_adr;
  logic [14:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic        cpu_reset;
  logic        err;
  logic [8:0]  words_loaded;

  int checks = 0;
  int failures = 0;

  // Write log captured at the falling edge
  logic [7:0]  log_adr  [0:299];
  logic [14:0] log_data [0:299];
  logic [1:0]  log_be   [0:299];
  int          nw = 0;
  int          ready_low = 0;
  logic        cpu_rst_low_seen = 1'b0;

  always #5 ph1 = ~ph1;

  hmmm_boot_loader #(.ADDR_W(8), .WORD_W(15)) dut (
    .ph1(ph1), .reset(reset),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .cpu_adr(cpu_adr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be),
    .cpu_reset(cpu_reset), .err(err), .words_loaded(words_loaded)
  );

  always @(negedge ph1) begin
    if (mem_we && nw < 300) begin
      log_adr[nw]  = mem_adr;
      log_data[nw] = mem_wdata;
      log_be[nw]   = mem_be;
      nw = nw + 1;
    end
    if (host_valid && !host_ready) ready_low = ready_low + 1;
    if (!cpu_reset) cpu_rst_low_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  // Presents a byte and returns 1 time unit after the edge that accepts it;
  // host_valid is left high so consecutive sends form a continuous stream.
  task automatic send(input logic [7:0] b);
    int w;
    host_valid = 1'b1;
    host_data  = b;
    w = 0;
    @(negedge ph1);
    while (!host_ready && w < 8) begin
      w++;
      @(negedge ph1);
    end
    check("send_ready_timeout", {31'd0, host_ready}, 32'd1);
    @(posedge ph1);
    #1;
  endtask

  initial begin
    logic [7:0] kb;
    reset = 1'b1; host_valid = 1'b0; host_data = 8'h00;
    cpu_adr = 8'h00; cpu_we = 1'b0; cpu_wdata = 8'h00;

    // Reset state
    tick(); tick();
    @(negedge ph1);
    check("rst_cpu_reset_during", {31'd0, cpu_reset}, 32'd1);
    @(posedge ph1); #1;
    reset = 1'b0;
    @(negedge ph1);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_be", {30'd0, mem_be}, 32'd0);
    check("rst_host_ready", {31'd0, host_ready}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_words", {23'd0, words_loaded}, 32'd0);
    check("rst_mem_adr", {24'd0, mem_adr}, 32'd0);

    // Two-word load with host_valid held high throughout
    @(posedge ph1); #1;
    nw = 0; ready_low = 0; cpu_rst_low_seen = 1'b0;
    send(8'h4C); send(8'h10); send(8'h02);
    send(8'h7F); send(8'hAA); send(8'h01); send(8'h55);
    tick();
    host_valid = 1'b0;
    tick();
    @(negedge ph1);
    check("ld2_nwrites", nw, 32'd2);
    check("ld2_adr0", {24'd0, log_adr[0]}, 32'h10);
    check("ld2_data0", {17'd0, log_data[0]}, 32'h7FAA);
    check("ld2_be0", {30'd0, log_be[0]}, 32'd3);
    check("ld2_adr1", {24'd0, log_adr[1]}, 32'h11);
    check("ld2_data1", {17'd0, log_data[1]}, 32'h0155);
    check("ld2_words", {23'd0, words_loaded}, 32'd2);
    check("ld2_ready_low", ready_low, 32'd2);
    check("ld2_cpu_reset_held", {31'd0, cpu_rst_low_seen}, 32'd0);
    check("ld2_idle_ready", {31'd0, host_ready}, 32'd1);
    check("ld2_mem_adr", {24'd0, mem_adr}, 32'h12);
    check("ld2_err", {31'd0, err}, 32'd0);

    // Address wrap, HI byte bit 7 ignored
    @(posedge ph1); #1;
    nw = 0;
    send(8'h4C); send(8'hFF); send(8'h02);
    send(8'h92); send(8'h34); send(8'h56); send(8'h78);
    tick();
    host_valid = 1'b0;
    tick();
    @(negedge ph1);
    check("wrap_nwrites", nw, 32'd2);
    check("wrap_adr0", {24'd0, log_adr[0]}, 32'hFF);
    check("wrap_data0", {17'd0, log_data[0]}, 32'h1234);
    check("wrap_adr1", {24'd0, log_adr[1]}, 32'h00);
    check("wrap_data1", {17'd0, log_data[1]}, 32'h5678);
    check("wrap_words", {23'd0, words_loaded}, 32'd2);

    // Count byte 0x00 -> 256 words starting at 0x80
    @(posedge ph1); #1;
    nw = 0;
    send(8'h4C); send(8'h80); send(8'h00);
    for (int k = 0; k < 256; k++) begin
      kb = k[7:0];
      send(kb);
      send(~kb);
    end
    tick();
    host_valid = 1'b0;
    tick();
    @(negedge ph1);
    check("full_nwrites", nw, 32'd256);
    check("full_words", {23'd0, words_loaded}, 32'd256);
    for (int k = 0; k < 256; k++) begin
      kb = k[7:0];
      check("full_adr", {24'd0, log_adr[k]}, {24'd0, kb + 8'h80});
      check("full_data", {17'd0, log_data[k]}, {17'd0, kb[6:0], ~kb});
    end

    // Bad command sets err; a later load leaves it set
    @(posedge ph1); #1;
    send(8'h99);
    host_valid = 1'b0;
    @(negedge ph1);
    check("bad_err_set", {31'd0, err}, 32'd1);
    @(posedge ph1); #1;
    nw = 0;
    send(8'h4C); send(8'h05); send(8'h01); send(8'h00); send(8'h01);
    tick();
    host_valid = 1'b0;
    tick();
    @(negedge ph1);
    check("bad_err_sticky", {31'd0, err}, 32'd1);
    check("bad_nwrites", nw, 32'd1);
    check("bad_data", {17'd0, log_data[0]}, 32'h0001);
    check("bad_words", {23'd0, words_loaded}, 32'd1);

    // Core bus ignored outside RUN
    @(posedge ph1); #1;
    cpu_adr = 8'h20; cpu_we = 1'b1; cpu_wdata = 8'h3C;
    @(negedge ph1);
    check("idle_cpu_we_ignored", {31'd0, mem_we}, 32'd0);
    check("idle_mem_adr", {24'd0, mem_adr}, 32'h06);

    // Go, core pass-through, ignored bytes in RUN, halt
    @(posedge ph1); #1;
    send(8'h47);
    host_valid = 1'b0;
    @(negedge ph1);
    check("go_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("run_mem_adr", {24'd0, mem_adr}, 32'h20);
    check("run_mem_wdata", {17'd0, mem_wdata}, 32'h003C);
    check("run_mem_be", {30'd0, mem_be}, 32'd1);
    check("run_mem_we", {31'd0, mem_we}, 32'd1);
    check("run_host_ready", {31'd0, host_ready}, 32'd1);
    @(posedge ph1); #1;
    send(8'h99);
    host_valid = 1'b0;
    @(negedge ph1);
    check("run_err_unchanged", {31'd0, err}, 32'd1);
    check("run_still_running", {31'd0, cpu_reset}, 32'd0);
    @(posedge ph1); #1;
    host_valid = 1'b1; host_data = 8'h48;
    @(negedge ph1);
    check("halt_cycle_we_pass", {31'd0, mem_we}, 32'd1);
    check("halt_cycle_be_pass", {30'd0, mem_be}, 32'd1);
    @(posedge ph1); #1;
    host_valid = 1'b0;
    @(negedge ph1);
    check("halt_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("halt_mem_we", {31'd0, mem_we}, 32'd0);
    check("halt_mem_be", {30'd0, mem_be}, 32'd0);
    check("halt_mem_adr", {24'd0, mem_adr}, 32'h06);
    @(posedge ph1); #1;
    cpu_we = 1'b0;

    // Reset after HI byte abandons the word
    @(posedge ph1); #1;
    send(8'h4C); send(8'h30); send(8'h01); send(8'h7F);
    host_valid = 1'b0;
    nw = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge ph1);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_words", {23'd0, words_loaded}, 32'd0);
    check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("abort_ready", {31'd0, host_ready}, 32'd1);
    check("abort_mem_adr", {24'd0, mem_adr}, 32'h00);
    tick(); tick(); tick();
    @(negedge ph1);
    check("abort_no_write", nw, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
